// File: rtl/inst_mem_sync.sv
// inst_mem_sync
// Loadable, synchronous instruction memory for the CPU fetch stage.
// After reset a sequencer writes FILL_WORD into every word. After that the
// loader port and the pipelined fetch port share the single array port.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   load_en      loader write strobe; it has priority over fetch
//   load_addr    word index to write
//   load_data    word to write
//   fetch_req    fetch request
//   address      byte address of the fetch
//   fetch_ready  the fetch is accepted on this edge when fetch_req is also high
//   instruction  fetched word; it holds its last value between results
//   inst_valid   one-cycle pulse per accepted fetch, READ_LATENCY cycles later
//   fault        misaligned or out-of-range fetch; qualified by inst_valid
//   init_done    high once the fill sequence has finished
//
// READ_LATENCY must be 1 or 2. Any value above 1 is treated as 2.
module inst_mem_sync #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 5,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  output logic                  fault,
  output logic                  init_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] cnt_reg, cnt_next;

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. The fill leaves INIT right after it writes the last
  // word, which is when the counter is all ones.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_INIT) begin
      cnt_next = cnt_reg + 1'b1;
      if (&cnt_reg) begin
        state_next = ST_RUN;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and selection of the write port
  // ---------------------------------------------------------------------
  always_comb begin
    fetch_ready = 1'b0;
    init_done   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = cnt_reg;
    wr_data     = FILL_WORD;
    if (state_reg == ST_INIT) begin
      wr_en = 1'b1;
    end else begin
      init_done   = 1'b1;
      fetch_ready = !load_en;
      if (load_en) begin
        wr_en   = 1'b1;
        wr_addr = load_addr;
        wr_data = load_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Fetch decode. Address bits above the array are not ignored: any set
  // bit there is a fault, so an address never wraps onto a valid word.
  // ---------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] high_bits;
  logic                  fetch_fault;
  logic                  accept;

  assign word_idx    = address[DEPTH_LOG2+1:2];
  assign high_bits   = address >> (DEPTH_LOG2 + 2);
  assign fetch_fault = (address[1:0] != 2'b00) || (high_bits != '0);
  assign accept      = fetch_req && fetch_ready;

  // ---------------------------------------------------------------------
  // Array: one write port and one registered read port. The array is read
  // only on an accepted fetch, and the write port never serves a load in
  // that same cycle.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data_reg <= mem[word_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Stage 0 control. bad0_reg is sticky. It is set when the last accepted
  // fetch was a fault, and it is also set by reset. The stage-0 word then
  // shows FILL_WORD without putting a reset on the array read register,
  // and it keeps showing FILL_WORD between results.
  // ---------------------------------------------------------------------
  logic                  valid0_reg;
  logic                  fault0_reg;
  logic                  bad0_reg;
  logic [DATA_WIDTH-1:0] data0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid0_reg <= 1'b0;
      fault0_reg <= 1'b0;
      bad0_reg   <= 1'b1;
    end else begin
      valid0_reg <= accept;
      fault0_reg <= accept && fetch_fault;
      if (accept) begin
        bad0_reg <= fetch_fault;
      end
    end
  end

  assign data0 = bad0_reg ? FILL_WORD : rd_data_reg;

  // ---------------------------------------------------------------------
  // Optional second output register. Its data only advances when stage 0
  // holds a result, so the output word holds its last value between
  // results.
  // ---------------------------------------------------------------------
  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic                  valid1_reg;
      logic                  fault1_reg;
      logic [DATA_WIDTH-1:0] data1_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid1_reg <= 1'b0;
          fault1_reg <= 1'b0;
          data1_reg  <= FILL_WORD;
        end else begin
          valid1_reg <= valid0_reg;
          fault1_reg <= fault0_reg;
          if (valid0_reg) begin
            data1_reg <= data0;
          end
        end
      end

      assign instruction = data1_reg;
      assign inst_valid  = valid1_reg;
      assign fault       = fault1_reg;
    end else begin : g_lat1
      assign instruction = data0;
      assign inst_valid  = valid0_reg;
      assign fault       = fault0_reg;
    end
  endgenerate

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
Parametrised, synchronous, loadable instruction memory for the next-generation CPU fetch stage. It replaces the fixed 32-word combinational ROM with a RAM array of configurable depth and width.
- A loader port writes program words.
- A pipelined fetch port uses a request/ready handshake and has a configurable 1- or 2-cycle read latency.
- Misaligned and out-of-range fetches return a fault plus a safe instruction word.
- After reset, a hardware init sequencer fills the whole array with a NOP word.

Parameters:
DATA_WIDTH, 32, instruction word width in bits.
ADDR_WIDTH, 32, byte-address width of the fetch port.
DEPTH_LOG2, 5, log2 of word count; DEPTH = 2**DEPTH_LOG2 (default 32 words).
READ_LATENCY, 1, cycles from fetch acceptance to instruction output; legal values 1 or 2 only.
FILL_WORD, 32'h0000_0000, word written by init and returned on fault (MIPS NOP, SLL $0,$0,0).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
load_en  input  1  write strobe for the loader port.
load_addr  input  DEPTH_LOG2  word index to write.
load_data  input  DATA_WIDTH  word to write.
fetch_req  input  1  fetch request.
address  input  ADDR_WIDTH  byte address of the fetch.
fetch_ready  output  1  fetch accepted this cycle when fetch_req and fetch_ready are both high.
instruction  output  DATA_WIDTH  fetched word; qualified by inst_valid.
inst_valid  output  1  one-cycle pulse per accepted fetch.
fault  output  1  qualified by inst_valid; high when the fetch was misaligned or out of range.
init_done  output  1  high once the init fill has completed.

Behaviour:
Reset:
- Applies on any edge where reset=1: state<=INIT, init counter<=0, all pipeline valid bits cleared.
- Reset outputs: instruction=FILL_WORD, inst_valid=0, fault=0, fetch_ready=0, init_done=0.
- Reset mid-operation: all in-flight fetches are dropped (never emitted) and INIT restarts at word 0.

FSM, two states (INIT, RUN):
- INIT: each cycle writes FILL_WORD to mem[cnt] and increments cnt. After writing word DEPTH-1, transition to RUN.
- INIT therefore occupies exactly DEPTH cycles after reset deasserts. load_en and fetch_req are ignored in INIT.
- RUN: init_done=1. Never leaves RUN except via reset.

Loader port:
- In RUN, load_en=1 writes load_data to mem[load_addr] at the edge.

Fetch port:
- fetch_ready = (state==RUN) && !load_en. Load takes priority over fetch, so a read and a write never occur in the same cycle.
- Word index = address[DEPTH_LOG2+1:2].
- fault condition = (address[1:0]!=0) OR (address[ADDR_WIDTH-1:DEPTH_LOG2+2]!=0).
- The array is read in the acceptance cycle. A later load to the same word does not alter a fetch that is already in flight.
- READ_LATENCY=1: the registered result appears the cycle after acceptance.
- READ_LATENCY=2: one extra output pipeline register.
- Fully pipelined: one fetch may be accepted every cycle, and results emerge in order with no bubbles. There is no output backpressure.
- On a fault fetch: instruction=FILL_WORD, fault=1. The array contents are not used.
- When inst_valid=0: instruction holds its last value and fault=0.

Width rules:
- No wrap-around. An out-of-range address is a fault, never aliased onto a valid word.
- The loader port can only address valid words because load_addr is exactly DEPTH_LOG2 bits wide.

Test Plan:
1. Deassert reset with DEPTH=32 → fetch_ready and init_done stay 0 for exactly 32 cycles, then go high. Fetch 0x00 → instruction=0x0000_0000, fault=0.
2. Load word 0 = 0x3C01_0000 and word 1 = 0x3424_0050; fetch 0x04 (READ_LATENCY=1) → one cycle later inst_valid=1, instruction=0x3424_0050.
3. Back-to-back fetches 0x00, 0x04, 0x7C with word 31 loaded as 0x03E0_0008 → three consecutive inst_valid pulses: 0x3C01_0000, 0x3424_0050, 0x03E0_0008.
4. Fetch 0x06 → fault=1, instruction=FILL_WORD. Fetch 0x80 → fault=1. Fetch 0x7C → fault=0.
5. Hold load_en=1 with fetch_req=1 → fetch_ready=0 and no inst_valid. With READ_LATENCY=2, accept fetch 0x04, then load word 1 = 0x1234_5678 on the next cycle → output two cycles after acceptance is still the old 0x3424_0050.
6. Assert reset with two fetches in flight → no inst_valid follows. INIT restarts, and afterwards previously loaded words read back as 0x0000_0000.
